// File: rtl/reduce_result_buffer.sv
// ----------------------------------------------------------------------------
// reduce_result_buffer
//   Captures single-cycle block-sum pulses from the reduction stage into a
//   small FWFT FIFO. Each entry is tagged with a sequence number and the block
//   mean (sum >> SHIFT). Entries go to the readout side over valid/ready.
//   Results that arrive while the buffer is full are dropped. A sticky
//   overflow flag and a saturating drop counter record these losses.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   sum_data     block sum from the reduction stage
//   sum_valid    one-cycle pulse; sum_data is valid (no backpressure)
//   m_valid      head entry available (level != 0)
//   m_ready      consumer accepts the head entry
//   m_sum        head entry sum   (reads 0 when empty)
//   m_mean       head entry mean  (reads 0 when empty)
//   m_seq        head entry tag   (reads 0 when empty)
//   level        current occupancy, 0..DEPTH
//   clr_status   clears overflow and drop_count (a same-cycle drop wins)
//   overflow     sticky: a result was dropped
//   drop_count   saturating count of dropped results
// ----------------------------------------------------------------------------
module reduce_result_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SHIFT  = 10,
    parameter int unsigned SEQ_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        sum_data,
    input  logic                     sum_valid,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_sum,
    output logic [DATA_W-1:0]        m_mean,
    output logic [SEQ_W-1:0]         m_seq,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     clr_status,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [DATA_W-1:0] sum_mem  [DEPTH];
    logic [DATA_W-1:0] mean_mem [DEPTH];
    logic [SEQ_W-1:0]  seq_mem  [DEPTH];

    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [SEQ_W-1:0]  seq;

    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    // A pop requires a valid head, so an empty buffer never bypasses an
    // incoming sum straight to the output. A full buffer accepts a push only
    // when the head leaves in the same cycle.
    always_comb begin
        full = (level == FULL_LEVEL);
        pop  = m_valid && m_ready;
        push = sum_valid && (!full || pop);
        drop = sum_valid && full && !pop;
    end

    assign m_valid = (level != '0);

    // Outputs are gated so they read 0 whenever the buffer is empty, which
    // includes right after reset (storage itself is not cleared).
    assign m_sum  = m_valid ? sum_mem[rd_ptr]  : '0;
    assign m_mean = m_valid ? mean_mem[rd_ptr] : '0;
    assign m_seq  = m_valid ? seq_mem[rd_ptr]  : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            sum_mem[wr_ptr]  <= sum_data;
            mean_mem[wr_ptr] <= sum_data >> SHIFT;
            seq_mem[wr_ptr]  <= seq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            seq        <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            // Pointers wrap naturally modulo DEPTH (power of two).
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end

            // A drop in the same cycle as clr_status restarts the count at 1.
            if (drop) begin
                overflow <= 1'b1;
                if (clr_status) begin
                    drop_count <= 16'd1;
                end else if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end else if (clr_status) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reduce_result_buffer.sv
// ----------------------------------------------------------------------------
// tb_reduce_result_buffer
//   Scoreboard bench: the stimulus process pushes each entry the buffer is
//   expected to accept into a queue; a monitor on the falling edge compares
//   the presented head against the queue front and pops on handshake.
// ----------------------------------------------------------------------------
module tb_reduce_result_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sum_data;
    logic        sum_valid;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_sum;
    logic [31:0] m_mean;
    logic [7:0]  m_seq;
    logic [2:0]  level;
    logic        clr_status;
    logic        overflow;
    logic [15:0] drop_count;

    reduce_result_buffer #(
        .DEPTH (4),
        .DATA_W(32),
        .SHIFT (10),
        .SEQ_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sum_data  (sum_data),
        .sum_valid (sum_valid),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sum     (m_sum),
        .m_mean    (m_mean),
        .m_seq     (m_seq),
        .level     (level),
        .clr_status(clr_status),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int unsigned npass  = 0;
    int unsigned ntotal = 0;

    // Expected entries {sum, mean, seq}, oldest first.
    logic [71:0] q[$];

    // Bench-side model of occupancy and status.
    int unsigned m_level = 0;
    logic [7:0]  m_seqc  = '0;
    logic        m_ovf   = 1'b0;
    logic [15:0] m_drops = '0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        ntotal++;
        if (act === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: head must match queue front whenever valid; pop on handshake.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("valid_vs_queue", 72'(m_valid), 72'(q.size() != 0));
            if (m_valid && q.size() != 0) begin
                chk("head_entry", {m_sum, m_mean, m_seq}, q[0]);
                if (m_ready) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus. Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic sv, input logic [31:0] d, input logic rdy, input logic clr);
        logic pop;
        logic full;
        sum_valid  = sv;
        sum_data   = d;
        m_ready    = rdy;
        clr_status = clr;
        @(posedge clk);
        pop  = (m_level != 0) && rdy;
        full = (m_level == 4);
        if (sv && (!full || pop)) begin
            q.push_back({d, d >> 10, m_seqc});
            m_seqc = m_seqc + 8'd1;
            if (!pop) m_level++;
        end else begin
            if (pop) m_level--;
            if (sv) begin
                m_ovf = 1'b1;
                if (clr) m_drops = 16'd1;
                else if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end else if (clr) begin
                m_ovf   = 1'b0;
                m_drops = '0;
            end
        end
        #1;
        sum_valid  = 1'b0;
        clr_status = 1'b0;
    endtask

    task automatic chk_status();
        chk("level",      72'(level),      72'(m_level));
        chk("overflow",   72'(overflow),   72'(m_ovf));
        chk("drop_count", 72'(drop_count), 72'(m_drops));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        sum_valid  = 1'b0;
        m_ready    = 1'b0;
        clr_status = 1'b0;
        @(posedge clk);
        q.delete();
        m_level = 0;
        m_seqc  = '0;
        m_ovf   = 1'b0;
        m_drops = '0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        sum_data   = '0;
        sum_valid  = 1'b0;
        m_ready    = 1'b0;
        clr_status = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_m_valid", 72'(m_valid), 72'(0));
        chk("rst_level",   72'(level),   72'(0));
        chk("rst_ovf",     72'(overflow), 72'(0));
        chk("rst_drops",   72'(drop_count), 72'(0));
        chk("rst_head",    {m_sum, m_mean, m_seq}, 72'(0));

        // Single result, consumer ready
        step(1'b1, 32'h0000_0400, 1'b0, 1'b0);
        chk("single_valid", 72'(m_valid), 72'(1));
        chk("single_sum",   72'(m_sum),   72'(32'h400));
        chk("single_mean",  72'(m_mean),  72'(32'h1));
        chk("single_seq",   72'(m_seq),   72'(0));
        chk("single_level", 72'(level),   72'(1));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("single_popped_valid", 72'(m_valid), 72'(0));
        chk("single_popped_level", 72'(level),   72'(0));

        // Backpressure and fill (fresh seq numbering)
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 32'(i) << 12, 1'b0, 1'b0);
            chk_status();
        end
        chk("fill_level", 72'(level), 72'(4));
        chk("fill_head",  72'(m_sum), 72'(32'h1000));
        step(1'b0, '0, 1'b0, 1'b0);
        chk("fill_stable", 72'(m_sum), 72'(32'h1000));

        // Overflow: two drops while full
        step(1'b1, 32'hDEAD_0000, 1'b0, 1'b0);
        step(1'b1, 32'hBEEF_0000, 1'b0, 1'b0);
        chk("ovf_flag",  72'(overflow),   72'(1));
        chk("ovf_drops", 72'(drop_count), 72'(2));
        chk("ovf_level", 72'(level),      72'(4));
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_flag",  72'(overflow),   72'(0));
        chk("clr_drops", 72'(drop_count), 72'(0));

        // Full with simultaneous push and pop: accepted with seq 4
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("pp_level", 72'(level),    72'(4));
        chk("pp_ovf",   72'(overflow), 72'(0));
        chk("pp_head",  72'(m_sum),    72'(32'h2000));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk_status();
        end
        chk("tail_mean", 72'(m_mean), 72'(32'h003F_FFFF));
        chk("tail_seq",  72'(m_seq),  72'(4));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_level", 72'(level), 72'(0));

        // Sequence wrap: 257 results through a free-running consumer
        do_reset();
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 32'(i) * 32'd1000, 1'b1, 1'b0);
        end
        chk("wrap_last_seq", 72'(m_seq), 72'(0));
        chk("wrap_level",    72'(level), 72'(1));
        step(1'b0, '0, 1'b1, 1'b0);

        // Drop coinciding with clr_status: drop wins
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0001_0000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h5, 1'b0, 1'b0);
        step(1'b1, 32'h6, 1'b0, 1'b0);
        chk("pre_coll_drops", 72'(drop_count), 72'(2));
        step(1'b1, 32'h7, 1'b0, 1'b1);
        chk("coll_ovf",   72'(overflow),   72'(1));
        chk("coll_drops", 72'(drop_count), 72'(1));

        // Saturation of drop_count
        for (int i = 0; i < 65540; i++) step(1'b1, 32'h9, 1'b0, 1'b0);
        chk("sat_drops", 72'(drop_count), 72'(16'hFFFF));
        chk_status();
        step(1'b0, '0, 1'b0, 1'b1);
        chk_status();

        // Reset mid-operation with three entries pending
        step(1'b0, '0, 1'b1, 1'b0);
        chk("pre_rst_level", 72'(level),   72'(3));
        chk("pre_rst_valid", 72'(m_valid), 72'(1));
        step(1'b1, 32'h77, 1'b0, 1'b0);
        do_reset();
        chk("mid_rst_valid", 72'(m_valid),  72'(0));
        chk("mid_rst_level", 72'(level),    72'(0));
        chk("mid_rst_ovf",   72'(overflow), 72'(0));
        step(1'b1, 32'h0000_0800, 1'b0, 1'b0);
        chk("post_rst_seq",  72'(m_seq),  72'(0));
        chk("post_rst_mean", 72'(m_mean), 72'(2));
        step(1'b0, '0, 1'b1, 1'b0);
        chk_status();

        @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/reduce_result_buffer.md
Name: reduce_result_buffer

Overview:
- Downstream consumer of the block-sum reduction stage.
- Captures each single-cycle sum pulse (source has no backpressure) into a small FIFO.
- Tags each entry with a sequence number and a precomputed block mean.
- Presents entries to the host/readout side over a valid/ready handshake; flags and counts results lost to a full buffer.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- DATA_W, 32, width of sum and mean fields.
- SHIFT, 10, log2 of samples per block; mean = sum >> SHIFT.
- SEQ_W, 8, sequence tag width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- sum_data  input  DATA_W  block sum from reduction stage
- sum_valid  input  1  one-cycle pulse, sum_data valid
- m_valid  output  1  head entry available
- m_ready  input  1  consumer accepts head entry
- m_sum  output  DATA_W  head entry sum
- m_mean  output  DATA_W  head entry mean
- m_seq  output  SEQ_W  head entry sequence tag
- level  output  $clog2(DEPTH)+1  current occupancy
- clr_status  input  1  clears overflow and drop_count
- overflow  output  1  sticky: a result was dropped
- drop_count  output  16  saturating count of dropped results

Behaviour:
- Reset: rst synchronous, active-high; clock clk. On reset:
  - Pointers, level, seq counter, overflow and drop_count all go to 0.
  - m_valid = 0. m_sum, m_mean and m_seq read as 0.
  - Stored entries are discarded, including a reset asserted mid-stream or with m_valid high.
- Pop:
  - Occurs when m_valid && m_ready in the cycle.
  - m_sum, m_mean and m_seq hold stable while m_valid=1 and m_ready=0.
- Push:
  - Occurs when sum_valid=1 and either level < DEPTH, or level == DEPTH with a pop in the same cycle.
  - Stored entry = {sum_data, sum_data >> SHIFT (logical, zero-fill), seq}.
  - seq increments by 1 per accepted push and wraps (2^SEQ_W - 1) -> 0. Dropped results do not consume a seq value.
- Latency and ordering:
  - FWFT. A push into an empty buffer gives m_valid=1 on the next cycle with that entry at the head.
  - No same-cycle bypass: when empty, sum_valid and m_ready together do not produce a pop that cycle.
  - Entries emerge in push order.
- Level:
  - +1 on push only, -1 on pop only, unchanged on push+pop or neither.
  - m_valid = (level != 0).
- Drop: sum_valid=1 while level == DEPTH and no pop that cycle.
  - Entry is discarded and seq is unchanged.
  - overflow <= 1 next cycle.
  - drop_count increments and saturates at 0xFFFF.
- clr_status:
  - Sets overflow <= 0 and drop_count <= 0.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
  - Has no effect on FIFO contents or seq.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by level, not by pointer equality.
- m_ready while m_valid=0: ignored.

Test Plan:
- Single result, consumer ready:
  - Stimulus: reset, then sum_valid with sum_data=0x0000_0400.
  - Required: next cycle m_valid=1, m_sum=0x400, m_mean=0x1, m_seq=0, level=1.
  - Required after pop with m_ready=1: m_valid=0 and level=0 the following cycle.
- Backpressure and fill:
  - Stimulus: m_ready=0, push 4 sums 0x1000, 0x2000, 0x3000, 0x4000.
  - Required: level=4 and m_sum stable at 0x1000.
  - Required after draining with m_ready=1 for 4 cycles: m_sum sequence 0x1000..0x4000, m_seq 0..3, m_mean 0x4, 0x8, 0xC, 0x10.
- Overflow:
  - Stimulus: with buffer full and m_ready=0, pulse sum_valid twice.
  - Required: overflow=1, drop_count=2, level=4, next accepted seq=4.
  - Stimulus: clr_status.
  - Required: overflow=0, drop_count=0.
- Full with simultaneous push and pop:
  - Stimulus: level=4, sum_valid=1 with sum_data=0xFFFF_FFFF, m_ready=1 in the same cycle.
  - Required: no drop, level stays 4, tail entry has m_mean=0x003F_FFFF.
- Sequence wrap and clear collision:
  - Stimulus: accept 257 results through a free-running consumer.
  - Required: m_seq goes 255 -> 0 -> ...; last seq=0.
  - Stimulus: a drop coinciding with clr_status.
  - Required: overflow=1, drop_count=1.
- Reset mid-operation:
  - Stimulus: level=3 with m_valid=1, assert rst for 1 cycle.
  - Required: m_valid=0, level=0, overflow=0.
  - Required on next push: m_seq=0.
